// File: rtl/synth_pkg.sv
// Shared types and widths for the synth control path.
package synth_pkg;

  localparam int SPI_REG_NUM_WIDTH   = 16;
  localparam int SPI_REG_VALUE_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } SpiState_t;

endpackage

// File: rtl/spi_input_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall detect
// from a history flop behind the last stage.
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_Clock,
  input  logic i_Reset_n,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_Async};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_Sync = sync_q[SYNC_STAGES-1];
  assign o_Rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign o_Fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/spi_register_bridge.sv
// SPI mode-0 slave: host frames become one-cycle register write strobes,
// while MISO returns the most recently latched synth sample.
module spi_register_bridge
  import synth_pkg::*;
#(
  parameter int REG_NUM_WIDTH   = SPI_REG_NUM_WIDTH,
  parameter int REG_VALUE_WIDTH = SPI_REG_VALUE_WIDTH,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset_n,
  input  logic                       i_SpiClock,
  input  logic                       i_SpiChipSelect_n,
  input  logic                       i_SpiMosi,
  output logic                       o_SpiMiso,
  input  logic [SAMPLE_WIDTH-1:0]    i_Sample,
  input  logic                       i_SampleReady,
  output logic                       o_RegisterWriteEnable,
  output logic [REG_NUM_WIDTH-1:0]   o_RegisterNumber,
  output logic [REG_VALUE_WIDTH-1:0] o_RegisterValue,
  output logic                       o_FrameError
);

  localparam int FRAME_BITS = REG_NUM_WIDTH + REG_VALUE_WIDTH;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_sync;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Async(i_SpiClock),
    .o_Sync(), .o_Rise(sclk_rise), .o_Fall(sclk_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Async(i_SpiChipSelect_n),
    .o_Sync(), .o_Rise(cs_rise), .o_Fall(cs_fall)
  );

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .i_Clock(i_Clock), .i_Reset_n(i_Reset_n), .i_Async(i_SpiMosi),
    .o_Sync(mosi_sync), .o_Rise(), .o_Fall()
  );

  SpiState_t                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]      rx_q, rx_d;
  logic [SAMPLE_WIDTH-1:0]    tx_q, tx_d;
  logic [SAMPLE_WIDTH-1:0]    sample_q, sample_d;
  logic                       pend_q, pend_d;
  logic                       we_q, we_d;
  logic                       err_q, err_d;
  logic [REG_NUM_WIDTH-1:0]   num_q, num_d;
  logic [REG_VALUE_WIDTH-1:0] val_q, val_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    pend_d   = 1'b0;
    err_d    = 1'b0;
    sample_d = i_SampleReady ? i_Sample : sample_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          tx_d    = sample_d;
        end
      end
      SHIFT: begin
        // CS release takes priority over a coincident SCLK rise.
        if (cs_rise) begin
          state_d = IDLE;
          err_d   = (cnt_q != '0);
        end else begin
          if (sclk_rise) begin
            rx_d  = {rx_q[FRAME_BITS-2:0], mosi_sync};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
              state_d = DONE;
              pend_d  = 1'b1;
            end
          end
          if (sclk_fall) begin
            tx_d = {tx_q[SAMPLE_WIDTH-2:0], 1'b0};
          end
        end
      end
      DONE: begin
        if (cs_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // The strobe is issued one cycle after DONE is entered, from the completed RX word.
    we_d  = pend_q;
    num_d = pend_q ? rx_q[FRAME_BITS-1 -: REG_NUM_WIDTH] : num_q;
    val_d = pend_q ? rx_q[REG_VALUE_WIDTH-1:0] : val_q;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      sample_q <= '0;
      pend_q   <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      num_q    <= '0;
      val_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      sample_q <= sample_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      err_q    <= err_d;
      num_q    <= num_d;
      val_q    <= val_d;
    end
  end

  assign o_SpiMiso             = (state_q == SHIFT) & tx_q[SAMPLE_WIDTH-1];
  assign o_RegisterWriteEnable = we_q;
  assign o_RegisterNumber      = num_q;
  assign o_RegisterValue       = val_q;
  assign o_FrameError          = err_q;

endmodule

// File: tb/tb_spi_register_bridge.sv
// Bench for spi_register_bridge: directed frames plus randomized frames with
// SCLK phase/period jitter, checked against a frame-level reference model.
module tb_spi_register_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sclk, cs_n, mosi, miso;
  logic [15:0] sample;
  logic        sample_rdy;
  logic        we, ferr;
  logic [15:0] reg_num;
  logic [7:0]  reg_val;

  spi_register_bridge dut (
    .i_Clock(clk), .i_Reset_n(rst_n),
    .i_SpiClock(sclk), .i_SpiChipSelect_n(cs_n), .i_SpiMosi(mosi), .o_SpiMiso(miso),
    .i_Sample(sample), .i_SampleReady(sample_rdy),
    .o_RegisterWriteEnable(we), .o_RegisterNumber(reg_num), .o_RegisterValue(reg_val),
    .o_FrameError(ferr)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state: pending writes, held outputs, latched sample, event counts.
  logic [23:0] exp_q[$];
  logic [15:0] held_num = '0;
  logic [7:0]  held_val = '0;
  logic [15:0] model_sample = '0;
  int exp_strobes = 0, n_strobes = 0;
  int exp_ferr = 0, n_ferr = 0;
  int cyc = 0, last_rise_cyc = 0;
  logic prev_we = 1'b0, prev_err = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    logic [23:0] e;
    if (we) begin
      check_val("we_width", {31'b0, prev_we}, 32'd0);
      n_strobes++;
      if (exp_q.size() == 0) begin
        check_val("we_spurious", {31'b0, we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("reg_num", {16'b0, reg_num}, {16'b0, e[23:8]});
        check_val("reg_val", {24'b0, reg_val}, {24'b0, e[7:0]});
        check_val("we_latency_le4", {31'b0, (cyc - last_rise_cyc) <= 4}, 32'd1);
        held_num = e[23:8];
        held_val = e[7:0];
      end
    end
    if (ferr) begin
      check_val("err_width", {31'b0, prev_err}, 32'd0);
      n_ferr++;
    end
    prev_we  = we;
    prev_err = ferr;
  end

  task automatic wait_clk(input int n, input bit jit);
    repeat (n) @(negedge clk);
    if (jit) #($urandom_range(0, 3));
  endtask

  task automatic pulse_sample(input logic [15:0] v);
    @(negedge clk);
    sample = v;
    sample_rdy = 1'b1;
    @(negedge clk);
    sample_rdy = 1'b0;
    model_sample = v;
  endtask

  task automatic spi_bit(input logic b, input int h, input bit jit, output logic m);
    mosi = b;
    wait_clk(h, jit);
    m = miso;
    sclk = 1'b1;
    last_rise_cyc = cyc;
    wait_clk(h, jit);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [31:0] data, input int nbits, input bit jit,
                           input bit rdy_at_fall, input logic [15:0] rdy_val);
    logic [31:0] t, miso_w, exp_w;
    logic [15:0] exp_sample;
    logic m;
    int h;
    if (nbits >= 24) begin
      t = data >> (nbits - 24);
      exp_q.push_back(t[23:0]);
      exp_strobes++;
    end else if (nbits > 0) begin
      exp_ferr++;
    end
    cs_n = 1'b0;
    if (rdy_at_fall) begin
      // Ready lands in the cycle where the synchronized CS fall is seen.
      repeat (2) @(negedge clk);
      sample = rdy_val;
      sample_rdy = 1'b1;
      @(negedge clk);
      sample_rdy = 1'b0;
      model_sample = rdy_val;
      wait_clk(2, jit);
    end else begin
      wait_clk(4, jit);
    end
    exp_sample = model_sample;
    miso_w = '0;
    exp_w  = '0;
    for (int i = 0; i < nbits; i++) begin
      h = jit ? int'($urandom_range(4, 6)) : 4;
      spi_bit(data[nbits-1-i], h, jit, m);
      miso_w = {miso_w[30:0], m};
      exp_w  = {exp_w[30:0], (i < 16) ? exp_sample[15-i] : 1'b0};
    end
    wait_clk(4, jit);
    cs_n = 1'b1;
    wait_clk(6, jit);
    if (nbits > 0) check_val("miso_bits", miso_w, exp_w);
    check_val("frame_err_cnt", n_ferr, exp_ferr);
    check_val("held_num", {16'b0, reg_num}, {16'b0, held_num});
    check_val("held_val", {24'b0, reg_val}, {24'b0, held_val});
  endtask

  initial begin
    logic m;
    logic [31:0] idle_w;
    int nb, r;
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    sample = '0; sample_rdy = 1'b0;
    wait_clk(3, 1'b0);
    check_val("rst_we", {31'b0, we}, 32'd0);
    check_val("rst_num", {16'b0, reg_num}, 32'd0);
    check_val("rst_val", {24'b0, reg_val}, 32'd0);
    check_val("rst_err", {31'b0, ferr}, 32'd0);
    check_val("rst_miso", {31'b0, miso}, 32'd0);
    rst_n = 1'b1;
    wait_clk(4, 1'b0);

    // Basic frame, then sample readback.
    spi_frame(32'h00C0057F, 24, 1'b0, 1'b0, 16'h0);
    wait_clk(20, 1'b0);
    check_val("hold_num_C005", {16'b0, reg_num}, 32'h0000C005);
    check_val("hold_val_7F", {24'b0, reg_val}, 32'h0000007F);
    pulse_sample(16'hA5C3);
    spi_frame(32'h00123456, 24, 1'b0, 1'b0, 16'h0);

    // Partial frame then a full one.
    spi_frame(32'h000002AB, 10, 1'b0, 1'b0, 16'h0);
    spi_frame(32'h00800102, 24, 1'b0, 1'b0, 16'h0);
    check_val("num_8001", {16'b0, reg_num}, 32'h00008001);
    check_val("val_02", {24'b0, reg_val}, 32'h00000002);

    // Overlong frame and back-to-back frames.
    spi_frame(32'hDEADBEEF, 32, 1'b0, 1'b0, 16'h0);
    spi_frame(32'h00654321, 24, 1'b0, 1'b0, 16'h0);
    spi_frame(32'h00ABCDEF, 24, 1'b0, 1'b0, 16'h0);

    // CS toggle with no clocks.
    spi_frame(32'h0, 0, 1'b0, 1'b0, 16'h0);

    // SCLK activity with CS high is ignored.
    idle_w = '0;
    for (int i = 0; i < 8; i++) begin
      spi_bit(1'($urandom_range(0, 1)), 4, 1'b0, m);
      idle_w = {idle_w[30:0], m};
    end
    wait_clk(6, 1'b0);
    check_val("idle_miso", idle_w, 32'd0);
    check_val("idle_no_strobe", n_strobes, exp_strobes);

    // 24th rise coincides with CS release: not counted, so an error rather than a write.
    cs_n = 1'b0;
    wait_clk(4, 1'b0);
    for (int i = 0; i < 23; i++) spi_bit(1'b1, 4, 1'b0, m);
    mosi = 1'b1;
    wait_clk(4, 1'b0);
    sclk = 1'b1;
    cs_n = 1'b1;
    wait_clk(4, 1'b0);
    sclk = 1'b0;
    wait_clk(6, 1'b0);
    exp_ferr++;
    check_val("cs_wins_err", n_ferr, exp_ferr);
    check_val("cs_wins_no_strobe", n_strobes, exp_strobes);

    // Reset in the middle of a frame.
    pulse_sample(16'h5A5A);
    cs_n = 1'b0;
    wait_clk(4, 1'b0);
    for (int i = 0; i < 12; i++) spi_bit(1'($urandom_range(0, 1)), 4, 1'b0, m);
    @(negedge clk);
    rst_n = 1'b0;
    cs_n = 1'b1;
    wait_clk(2, 1'b0);
    check_val("midrst_we", {31'b0, we}, 32'd0);
    check_val("midrst_num", {16'b0, reg_num}, 32'd0);
    check_val("midrst_val", {24'b0, reg_val}, 32'd0);
    check_val("midrst_err", {31'b0, ferr}, 32'd0);
    check_val("midrst_miso", {31'b0, miso}, 32'd0);
    held_num = '0;
    held_val = '0;
    model_sample = '0;
    rst_n = 1'b1;
    wait_clk(6, 1'b0);
    check_val("midrst_no_err", n_ferr, exp_ferr);
    spi_frame(32'h00C3A1F0, 24, 1'b0, 1'b0, 16'h0);

    // Sample ready coincident with the synchronized CS fall.
    pulse_sample(16'hBEEF);
    spi_frame(32'h00112233, 24, 1'b0, 1'b1, 16'h1234);

    // Randomized frames with period/phase jitter.
    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      nb = 0;
      else if (r <= 2) nb = $urandom_range(1, 23);
      else if (r == 3) nb = $urandom_range(25, 32);
      else             nb = 24;
      if ($urandom_range(0, 2) == 0) pulse_sample(16'($urandom));
      spi_frame($urandom, nb, 1'b1, ($urandom_range(0, 4) == 0), 16'($urandom));
    end

    wait_clk(10, 1'b0);
    check_val("strobe_total", n_strobes, exp_strobes);
    check_val("queue_empty", exp_q.size(), 32'd0);
    check_val("ferr_total", n_ferr, exp_ferr);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
